// File: rtl/parking_pkg.sv
// Shared parking-gate definitions: FSM state encoding, BCD digit constants and PIN width helper.
// Also imported by the gate controller, so keep it free of block-specific details.
package parking_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PRESENT = 2'd2
  } state_e;

  function automatic int pin_width(input int digits);
    return digits * BCD_W;
  endfunction

endpackage

// File: rtl/pin_entry_collector_if.sv
// Keypad/controller bundle for the PIN collector; master = keypad + gate controller side,
// slave = collector. Pass width follows DIGITS.
interface pin_entry_collector_if
  import parking_pkg::*;
#(
  parameter int DIGITS = 2
);

  localparam int W = pin_width(DIGITS);

  logic             sensorA;
  logic             key_valid;
  logic [BCD_W-1:0] key_code;
  logic             key_enter;
  logic             key_clear;
  logic             pass_ack;
  logic [W-1:0]     pass;
  logic             pass_valid;
  logic             key_err;
  logic             timeout;

  modport master (
    output sensorA, key_valid, key_code, key_enter, key_clear, pass_ack,
    input  pass, pass_valid, key_err, timeout
  );

  modport slave (
    input  sensorA, key_valid, key_code, key_enter, key_clear, pass_ack,
    output pass, pass_valid, key_err, timeout
  );

endinterface

// File: rtl/entry_timer.sv
// Idle-cycle counter for PIN entry: expires combinationally on its last count unless cleared that cycle.
// Built only with ENTRY_TIMEOUT_EN; 1-cycle clear-to-zero, no backpressure.
`ifdef ENTRY_TIMEOUT_EN
module entry_timer #(
  parameter int LIMIT = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic expire_o
);

  localparam int TW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [TW-1:0] LAST = TW'(LIMIT - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  assign expire_o = en_i && !clr_i && (cnt_q == LAST);

  // Held at zero whenever counting is disabled, so each COLLECT visit starts fresh.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!en_i || clr_i || expire_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/pin_entry_collector.sv
// Keypad PIN collector: gathers BCD digits while a vehicle is present, presents the PIN until acked.
// All outputs registered, 1-cycle enter->valid and ack->clear; optional idle timeout via ENTRY_TIMEOUT_EN.
module pin_entry_collector
  import parking_pkg::*;
#(
  parameter int DIGITS = 2
`ifdef ENTRY_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 25
`endif
) (
  input logic                  clk,
  input logic                  reset,
  pin_entry_collector_if.slave bus
);

  localparam int W  = pin_width(DIGITS);
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] FULL = CW'(DIGITS);

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_COLLECT = COLLECT;
  localparam logic [1:0] S_PRESENT = PRESENT;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  buf_q, buf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  pass_q, pass_d;
  logic          pass_vld_q, pass_vld_d;
  logic          key_err_q, key_err_d;

`ifdef ENTRY_TIMEOUT_EN
  logic timeout_q, timeout_d;
  logic strobe;
  logic tmr_expire;

  assign strobe = bus.key_valid || bus.key_enter || bus.key_clear;

  entry_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_entry_timer (
    .clk      (clk),
    .reset    (reset),
    .en_i     (state_q == S_COLLECT),
    .clr_i    (strobe),
    .expire_o (tmr_expire)
  );
`endif

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    pass_d     = pass_q;
    pass_vld_d = pass_vld_q;
    key_err_d  = 1'b0;
`ifdef ENTRY_TIMEOUT_EN
    timeout_d  = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.sensorA) begin
          state_d = S_COLLECT;
          buf_d   = '0;
          cnt_d   = '0;
        end
      end

      // Event priority: vehicle leaves, clear, enter, digit, then timer.
      S_COLLECT: begin
        if (!bus.sensorA) begin
          state_d = S_IDLE;
          buf_d   = '0;
          cnt_d   = '0;
        end else if (bus.key_clear) begin
          buf_d = '0;
          cnt_d = '0;
        end else if (bus.key_enter) begin
          if (cnt_q == FULL) begin
            state_d    = S_PRESENT;
            pass_d     = buf_q;
            pass_vld_d = 1'b1;
          end else begin
            key_err_d = 1'b1;
          end
        end else if (bus.key_valid) begin
          if ((bus.key_code <= BCD_MAX) && (cnt_q < FULL)) begin
            buf_d = (buf_q << BCD_W) | W'(bus.key_code);
            cnt_d = cnt_q + 1'b1;
          end else begin
            key_err_d = 1'b1;
          end
        end
`ifdef ENTRY_TIMEOUT_EN
        else if (tmr_expire) begin
          buf_d     = '0;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end
`endif
      end

      S_PRESENT: begin
        if (bus.pass_ack || !bus.sensorA) begin
          state_d    = bus.sensorA ? S_COLLECT : S_IDLE;
          pass_d     = '0;
          pass_vld_d = 1'b0;
          buf_d      = '0;
          cnt_d      = '0;
        end
      end

      default: begin
        state_d    = S_IDLE;
        buf_d      = '0;
        cnt_d      = '0;
        pass_d     = '0;
        pass_vld_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      buf_q      <= '0;
      cnt_q      <= '0;
      pass_q     <= '0;
      pass_vld_q <= 1'b0;
      key_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      pass_q     <= pass_d;
      pass_vld_q <= pass_vld_d;
      key_err_q  <= key_err_d;
    end
  end

`ifdef ENTRY_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.pass       = pass_q;
  assign bus.pass_valid = pass_vld_q;
  assign bus.key_err    = key_err_q;

endmodule

// File: tb/tb_pin_entry_collector.sv
// Directed bench for pin_entry_collector: per-cycle vector table plus hand sequences for timeout and reset.
module tb_pin_entry_collector;

`ifdef ENTRY_TIMEOUT_EN
  localparam logic TMO_EN = 1'b1;
`else
  localparam logic TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pin_entry_collector_if #(.DIGITS(2)) bus ();

  pin_entry_collector #(.DIGITS(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic       s;
    logic       kv;
    logic [3:0] code;
    logic       ke;
    logic       kc;
    logic       ack;
    logic [7:0] e_pass;
    logic       e_vld;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string n, input logic s, input logic kv, input logic [3:0] code,
                              input logic ke, input logic kc, input logic ack,
                              input logic [7:0] ep, input logic ev, input logic ee);
    vec_t v;
    v.name = n; v.s = s; v.kv = kv; v.code = code; v.ke = ke; v.kc = kc; v.ack = ack;
    v.e_pass = ep; v.e_vld = ev; v.e_err = ee;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic s, input logic kv, input logic [3:0] code,
                       input logic ke, input logic kc, input logic ack);
    bus.sensorA   = s;
    bus.key_valid = kv;
    bus.key_code  = code;
    bus.key_enter = ke;
    bus.key_clear = kc;
    bus.pass_ack  = ack;
  endtask

  // Inputs change 1 time unit after the edge; outputs are read 1 unit after the next edge.
  task automatic step(input logic s, input logic kv, input logic [3:0] code,
                      input logic ke, input logic kc, input logic ack);
    drive(s, kv, code, ke, kc, ack);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", n, act, exp);
    end
  endtask

  task automatic chk_out(input string n, input logic [7:0] p, input logic v, input logic e, input logic t);
    chk({n, ".pass"},       32'(bus.pass),       32'(p));
    chk({n, ".pass_valid"}, 32'(bus.pass_valid), 32'(v));
    chk({n, ".key_err"},    32'(bus.key_err),    32'(e));
    chk({n, ".timeout"},    32'(bus.timeout),    32'(t));
  endtask

  initial begin
    // Basic entry, hold, ack
    add("t1_arm",      1, 0, 4'h0, 0, 0, 0, 8'h00, 0, 0);
    add("t1_key2",     1, 1, 4'h2, 0, 0, 0, 8'h00, 0, 0);
    add("t1_key6",     1, 1, 4'h6, 0, 0, 0, 8'h00, 0, 0);
    add("t1_enter",    1, 0, 4'h0, 1, 0, 0, 8'h26, 1, 0);
    for (int i = 0; i < 10; i++)
      add("t1_hold",   1, (i == 3), 4'h9, (i == 5), (i == 7), 0, 8'h26, 1, 0);
    add("t1_ack",      1, 0, 4'h0, 0, 0, 1, 8'h00, 0, 0);
    // Invalid code and short PIN
    add("t2_keyB",     1, 1, 4'hB, 0, 0, 0, 8'h00, 0, 1);
    add("t2_errdrop",  1, 0, 4'h0, 0, 0, 0, 8'h00, 0, 0);
    add("t2_key3",     1, 1, 4'h3, 0, 0, 0, 8'h00, 0, 0);
    add("t2_short",    1, 0, 4'h0, 1, 0, 0, 8'h00, 0, 1);
    add("t2_key7",     1, 1, 4'h7, 0, 0, 0, 8'h00, 0, 0);
    add("t2_enter",    1, 0, 4'h0, 1, 0, 0, 8'h37, 1, 0);
    add("t2_ack",      1, 0, 4'h0, 0, 0, 1, 8'h00, 0, 0);
    // Overflow digit, then clear racing a digit
    add("t3_key2",     1, 1, 4'h2, 0, 0, 0, 8'h00, 0, 0);
    add("t3_key6",     1, 1, 4'h6, 0, 0, 0, 8'h00, 0, 0);
    add("t3_key5_ovf", 1, 1, 4'h5, 0, 0, 0, 8'h00, 0, 1);
    add("t3_enter",    1, 0, 4'h0, 1, 0, 0, 8'h26, 1, 0);
    add("t3_ack",      1, 0, 4'h0, 0, 0, 1, 8'h00, 0, 0);
    add("t3_key1",     1, 1, 4'h1, 0, 0, 0, 8'h00, 0, 0);
    add("t3_clr_key8", 1, 1, 4'h8, 0, 1, 0, 8'h00, 0, 0);
    add("t3_empty",    1, 0, 4'h0, 1, 0, 0, 8'h00, 0, 1);
    add("t3_key4",     1, 1, 4'h4, 0, 0, 0, 8'h00, 0, 0);
    add("t3_key5",     1, 1, 4'h5, 0, 0, 0, 8'h00, 0, 0);
    add("t3_enter",    1, 0, 4'h0, 1, 0, 0, 8'h45, 1, 0);
    // Vehicle leaves during PRESENT; IDLE ignores keys
    add("t4_leave",    0, 0, 4'h0, 0, 0, 0, 8'h00, 0, 0);
    add("t4_idle_key", 0, 1, 4'h3, 0, 0, 0, 8'h00, 0, 0);
    add("t4_idle_ent", 0, 0, 4'h0, 1, 0, 0, 8'h00, 0, 0);
    add("t4_idle_bad", 0, 1, 4'hB, 0, 0, 0, 8'h00, 0, 0);
    add("t4_rearm",    1, 0, 4'h0, 0, 0, 0, 8'h00, 0, 0);
    add("t4_empty",    1, 0, 4'h0, 1, 0, 0, 8'h00, 0, 1);
    add("t4_key9",     1, 1, 4'h9, 0, 0, 0, 8'h00, 0, 0);
    add("t4_key0",     1, 1, 4'h0, 0, 0, 0, 8'h00, 0, 0);
    add("t4_enter",    1, 0, 4'h0, 1, 0, 0, 8'h90, 1, 0);
    add("t4_ack_gone", 0, 0, 4'h0, 0, 0, 1, 8'h00, 0, 0);
    add("t4_idle",     0, 0, 4'h0, 0, 0, 0, 8'h00, 0, 0);

    reset = 1'b1;
    drive(1, 1, 4'hB, 1, 1, 1);
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 8'h00, 0, 0, 0);
    drive(0, 0, 4'h0, 0, 0, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].s, vecs[i].kv, vecs[i].code, vecs[i].ke, vecs[i].kc, vecs[i].ack);
      chk_out(vecs[i].name, vecs[i].e_pass, vecs[i].e_vld, vecs[i].e_err, 1'b0);
    end

    // A strobe in the would-be expiry cycle suppresses the timeout
    step(1, 0, 4'h0, 0, 0, 0);
    step(1, 1, 4'h1, 0, 0, 0);
    for (int i = 0; i < 24; i++) begin
      step(1, 0, 4'h0, 0, 0, 0);
      chk("t5_quiet_a.timeout", 32'(bus.timeout), 32'd0);
    end
    step(1, 1, 4'h3, 0, 0, 0);
    chk_out("t5_strobe_wins", 8'h00, 0, 0, 0);
    step(1, 0, 4'h0, 1, 0, 0);
    chk_out("t5_enter13", 8'h13, 1, 0, 0);
    step(1, 0, 4'h0, 0, 0, 1);
    chk_out("t5_ack", 8'h00, 0, 0, 0);

    // Timeout after 25 idle cycles discards the partial PIN
    step(1, 1, 4'h2, 0, 0, 0);
    for (int i = 0; i < 24; i++) begin
      step(1, 0, 4'h0, 0, 0, 0);
      chk("t5_quiet_b.timeout", 32'(bus.timeout), 32'd0);
    end
    step(1, 0, 4'h0, 0, 0, 0);
    chk_out("t5_expire", 8'h00, 0, 0, TMO_EN);
    step(1, 0, 4'h0, 0, 0, 0);
    chk_out("t5_pulse_end", 8'h00, 0, 0, 0);
    step(1, 0, 4'h0, 1, 0, 0);
    chk_out("t5_enter_err", 8'h00, 0, 1, 0);
    step(1, 1, 4'h5, 0, 0, 0);
    step(1, 1, 4'h5, 0, 0, 0);
    step(1, 0, 4'h0, 1, 0, 0);
    chk_out("t5_after", TMO_EN ? 8'h55 : 8'h25, 1, 0, 0);
    step(1, 0, 4'h0, 0, 0, 1);
    chk_out("t5_ack2", 8'h00, 0, 0, 0);

    // Reset during PRESENT
    step(1, 1, 4'h8, 0, 0, 0);
    step(1, 1, 4'h1, 0, 0, 0);
    step(1, 0, 4'h0, 1, 0, 0);
    chk_out("t6_present", 8'h81, 1, 0, 0);
    reset = 1'b1;
    step(1, 1, 4'hB, 0, 0, 0);
    chk_out("t6_reset", 8'h00, 0, 0, 0);
    reset = 1'b0;
    step(1, 0, 4'h0, 0, 0, 0);
    chk_out("t6_release", 8'h00, 0, 0, 0);
    step(1, 0, 4'h0, 1, 0, 0);
    chk_out("t6_collect", 8'h00, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
